// File: rtl/mm_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the Montgomery-multiplier bridge loader:
//   - state_e : loader FSM states
//   - address-map helpers, all expressed as functions of s (words per operand)
//     p_prime_0 @ 0, p @ 1..s, a @ s+1..2s, b @ 2s+1..3s, result @ s+1..2s
// -----------------------------------------------------------------------------
package mm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_READ  = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  // p_prime_0 always sits at the very bottom of the map, whatever s is.
  function automatic int P_PRIME_ADDR(input int s_words);
    return 0 * s_words;
  endfunction

  function automatic int P_BASE(input int s_words);
    return P_PRIME_ADDR(s_words) + 1;
  endfunction

  function automatic int A_BASE(input int s_words);
    return P_BASE(s_words) + s_words;
  endfunction

  function automatic int B_BASE(input int s_words);
    return A_BASE(s_words) + s_words;
  endfunction

  // The multiplier writes its result over operand a, so a chained squaring
  // can start again without reloading anything.
  function automatic int RES_BASE(input int s_words);
    return A_BASE(s_words);
  endfunction

endpackage : mm_pkg

// File: rtl/mm_skid_fifo2.sv
// -----------------------------------------------------------------------------
// mm_skid_fifo2
// Two-entry FIFO with valid/ready handshakes on both sides. Output data is
// taken straight from the storage registers, so it is held stable while
// out_valid_o is high and out_ready_i is low.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_valid_i/in_ready_o    write side handshake, in_data_i payload
//   out_valid_o/out_ready_i  read side handshake, out_data_o payload
//   count_o                  current occupancy (0..2)
// -----------------------------------------------------------------------------
module mm_skid_fifo2 #(
  parameter int W = 18
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_s, pop_s;

  // A full FIFO can still take a word in the same cycle its head leaves.
  assign in_ready_o  = (count_q != 2'd2) | out_ready_i;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign push_s      = in_valid_i & in_ready_o;
  assign pop_s       = out_valid_o & out_ready_i;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : mm_skid_fifo2

// File: rtl/mm_bridge_loader.sv
// -----------------------------------------------------------------------------
// mm_bridge_loader
// Streams operands from the host into the bridge BRAM, kicks the multiplier,
// waits for it to finish, then streams the s-word result back out.
// Ports:
//   clock_i, reset_n_i                 clock, asynchronous active-low reset
//   s_data_i/s_valid_i/s_ready_o       host operand stream (LSW first)
//   reuse_mod_i                        1 = keep p_prime_0/p, load a and b only
//   m_data_o/m_valid_o/m_last_o/m_ready_i  result stream
//   bram_addr_o/din_o/we_o/en_o, bram_dout_i  BRAM host port, 1-cycle read
//   mm_start_o, mm_done_i              multiplier handshake
//   busy_o                             high whenever not idle
// -----------------------------------------------------------------------------
module mm_bridge_loader
  import mm_pkg::*;
#(
  parameter  int s      = 8,
  localparam int ADDR_W = $clog2(4 * s)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [16:0]       s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              reuse_mod_i,
  output logic [16:0]       m_data_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [16:0]       bram_din_o,
  output logic              bram_we_o,
  output logic              bram_en_o,
  input  logic [16:0]       bram_dout_i,
  output logic              mm_start_o,
  input  logic              mm_done_i,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PP_ADDR   = ADDR_W'(P_PRIME_ADDR(s));
  localparam logic [ADDR_W-1:0] A_ADDR    = ADDR_W'(A_BASE(s));
  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(B_BASE(s) + s - 1);
  localparam logic [ADDR_W-1:0] RES_ADDR  = ADDR_W'(RES_BASE(s));
  localparam logic [ADDR_W-1:0] RES_LAST  = ADDR_W'(RES_BASE(s) + s - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mod_loaded_q, mod_loaded_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;

  logic              s_ready_s;
  logic              accept_s;
  logic              reuse_eff_s;
  logic              pop_s;
  logic              can_issue_s;
  logic [1:0]        occ_eff_s;
  logic              fifo_in_ready_s;
  logic [1:0]        fifo_count_s;
  logic [17:0]       fifo_dout_s;
  logic              bram_en_s, bram_we_s;
  logic [ADDR_W-1:0] bram_addr_s;
  logic [16:0]       bram_din_s;

  // Ready is gated by reset so nothing can be written while reset is held.
  assign s_ready_s   = reset_n_i & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
  assign accept_s    = s_valid_i & s_ready_s;
  // Reuse is only honoured once a complete modulus is known to be in BRAM.
  assign reuse_eff_s = reuse_mod_i & mod_loaded_q;
  assign pop_s       = m_valid_o & m_ready_i;
  // A word leaving the buffer this cycle frees its slot for the next read,
  // which is what lets the result stream run at one word per cycle.
  assign occ_eff_s   = fifo_count_s - {1'b0, pop_s};
  assign can_issue_s = ((occ_eff_s + {1'b0, rd_pend_q}) < 2'd2) & fifo_in_ready_s;

  // FSM next-state, address sequencing and BRAM port drive.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mod_loaded_d = mod_loaded_q;
    rd_pend_d    = 1'b0;
    rd_last_d    = 1'b0;
    bram_en_s    = 1'b0;
    bram_we_s    = 1'b0;
    bram_addr_s  = '0;
    bram_din_s   = 17'd0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          bram_en_s   = 1'b1;
          bram_we_s   = 1'b1;
          bram_din_s  = s_data_i;
          bram_addr_s = reuse_eff_s ? A_ADDR : PP_ADDR;
          addr_d      = bram_addr_s + ADDR_ONE;
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (accept_s) begin
          bram_en_s   = 1'b1;
          bram_we_s   = 1'b1;
          bram_din_s  = s_data_i;
          bram_addr_s = addr_q;
          if (addr_q == LOAD_LAST) begin
            mod_loaded_d = 1'b1;
            state_d      = ST_START;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_START: begin
        addr_d  = RES_ADDR;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (mm_done_i) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_READ: begin
        if (can_issue_s) begin
          bram_en_s   = 1'b1;
          bram_addr_s = addr_q;
          rd_pend_d   = 1'b1;
          rd_last_d   = (addr_q == RES_LAST);
          if (addr_q == RES_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end else begin
          state_d = ST_READ;
        end
      end

      ST_DRAIN: begin
        if (pop_s & m_last_o) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    start_d = (state_d == ST_START);
    busy_d  = (state_d != ST_IDLE);
  end

  // Loader state, counters and registered status outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      mod_loaded_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mod_loaded_q <= mod_loaded_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
    end
  end

  // Read data arrives one cycle after issue and is tagged with its last flag.
  mm_skid_fifo2 #(
    .W (18)
  ) u_out_fifo (
    .clk_i       (clock_i),
    .rst_ni      (reset_n_i),
    .in_valid_i  (rd_pend_q),
    .in_ready_o  (fifo_in_ready_s),
    .in_data_i   ({rd_last_q, bram_dout_i}),
    .out_valid_o (m_valid_o),
    .out_ready_i (m_ready_i),
    .out_data_o  (fifo_dout_s),
    .count_o     (fifo_count_s)
  );

  assign m_last_o    = fifo_dout_s[17];
  assign m_data_o    = fifo_dout_s[16:0];
  assign s_ready_o   = s_ready_s;
  assign bram_en_o   = bram_en_s;
  assign bram_we_o   = bram_we_s;
  assign bram_addr_o = bram_addr_s;
  assign bram_din_o  = bram_din_s;
  assign mm_start_o  = start_q;
  assign busy_o      = busy_q;

endmodule : mm_bridge_loader
